// File: rtl/bist_response_analyzer_if.sv
// Bundle for the RAM read-side BIST analyzer. It carries the mode select, the
// RAM read data, the BIST engine strobes and the result outputs.
interface bist_response_analyzer_if #(
  parameter int size = 8,
  parameter int aw   = 4,
  parameter int cw   = 8
);
  logic            sel;
  logic [size-1:0] ram_dout;
  logic [size-1:0] sys_dout;
  logic            start;
  logic            rd_en;
  logic [aw-1:0]   rd_addr;
  logic [size-1:0] exp_data;
  logic            test_end;
  logic            busy;
  logic            done;
  logic            pass;
  logic            fail;
  logic [cw-1:0]   fail_count;
  logic [aw-1:0]   first_fail_addr;
  logic [size-1:0] first_fail_data;

  // BIST engine / system side: drives mode, RAM data and strobes, reads results
  modport master (
    output sel, ram_dout, start, rd_en, rd_addr, exp_data, test_end,
    input  sys_dout, busy, done, pass, fail, fail_count,
           first_fail_addr, first_fail_data
  );

  // Analyzer side
  modport slave (
    input  sel, ram_dout, start, rd_en, rd_addr, exp_data, test_end,
    output sys_dout, busy, done, pass, fail, fail_count,
           first_fail_addr, first_fail_data
  );
endinterface

// File: rtl/bist_response_analyzer.sv
// Read-side BIST response analyzer. In functional mode (sel=0) RAM read data
// passes straight to the system. In test mode (sel=1) each BIST read is held in
// a one-deep stage and compared against the RAM data one cycle later; results
// are a sticky fail flag, a saturating fail count and the first miscompare's
// address and data.
module bist_response_analyzer #(
  parameter int size = 8,
  parameter int aw   = 4,
  parameter int cw   = 8
) (
  input logic                     clk,
  input logic                     rst,
  bist_response_analyzer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t          state_r;
  state_t          state_s;

  logic            pend_r;
  logic [aw-1:0]   st1_addr_r;
  logic [size-1:0] st1_data_r;

  logic            fail_r;
  logic            fail_s;
  logic [cw-1:0]   cnt_r;
  logic [cw-1:0]   cnt_s;
  logic [aw-1:0]   ffa_r;
  logic [aw-1:0]   ffa_s;
  logic [size-1:0] ffd_r;
  logic [size-1:0] ffd_s;

  logic            busy_r;
  logic            done_r;
  logic            pass_r;

  logic            clear_s;
  logic            capture_s;
  logic            cmp_s;
  logic            miss_s;

  // Functional-mode read path: zero latency, forced to zero while BIST owns the RAM
  assign bus.sys_dout = bus.sel ? {size{1'b0}} : bus.ram_dout;

  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.pass            = pass_r;
  assign bus.fail            = fail_r;
  assign bus.fail_count      = cnt_r;
  assign bus.first_fail_addr = ffa_r;
  assign bus.first_fail_data = ffd_r;

  // Next-state logic: sel=0 aborts from anywhere, start restarts from anywhere
  always_comb begin
    state_s = state_r;
    if (!bus.sel) begin
      state_s = IDLE;
    end else if (bus.start) begin
      state_s = RUN;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        RUN: begin
          if (bus.test_end) begin
            state_s = DRAIN;
          end else begin
            state_s = RUN;
          end
        end
        DRAIN:   state_s = DONE;
        DONE:    state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Compare controls: a start clears results and suppresses any compare in flight
  always_comb begin
    clear_s   = bus.sel & bus.start;
    capture_s = bus.sel & bus.rd_en & (state_r == RUN);
    cmp_s     = pend_r & bus.sel & ~bus.start;
    miss_s    = cmp_s & (bus.ram_dout != st1_data_r);
  end

  // Result update: clear on start, otherwise accumulate miscompares
  always_comb begin
    fail_s = fail_r;
    cnt_s  = cnt_r;
    ffa_s  = ffa_r;
    ffd_s  = ffd_r;
    if (clear_s) begin
      fail_s = 1'b0;
      cnt_s  = {cw{1'b0}};
      ffa_s  = {aw{1'b0}};
      ffd_s  = {size{1'b0}};
    end else if (miss_s) begin
      fail_s = 1'b1;
      if (cnt_r == {cw{1'b1}}) begin
        cnt_s = cnt_r;
      end else begin
        cnt_s = cnt_r + cw'(1);
      end
      // only the first miscompare of a run is captured
      if (!fail_r) begin
        ffa_s = st1_addr_r;
        ffd_s = bus.ram_dout;
      end else begin
        ffa_s = ffa_r;
        ffd_s = ffd_r;
      end
    end else begin
      fail_s = fail_r;
      cnt_s  = cnt_r;
    end
  end

  // State, compare stage and registered outputs; rst wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pend_r     <= 1'b0;
      st1_addr_r <= {aw{1'b0}};
      st1_data_r <= {size{1'b0}};
      fail_r     <= 1'b0;
      cnt_r      <= {cw{1'b0}};
      ffa_r      <= {aw{1'b0}};
      ffd_r      <= {size{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      // pending lasts exactly one cycle; back-to-back reads reload it
      pend_r  <= capture_s;
      if (capture_s) begin
        st1_addr_r <= bus.rd_addr;
        st1_data_r <= bus.exp_data;
      end else begin
        st1_addr_r <= st1_addr_r;
        st1_data_r <= st1_data_r;
      end
      fail_r <= fail_s;
      cnt_r  <= cnt_s;
      ffa_r  <= ffa_s;
      ffd_r  <= ffd_s;
      busy_r <= (state_s == RUN) || (state_s == DRAIN);
      done_r <= (state_s == DONE);
      pass_r <= (state_s == DONE) && !fail_s;
    end
  end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench for bist_response_analyzer: one default instance (cw=8) and
// one with a 2-bit fail counter for saturation, both driven identically.
module tb_bist_response_analyzer;

  logic       clk;
  logic       rst;
  logic       sel;
  logic [7:0] ram_dout;
  logic       start;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] exp_data;
  logic       test_end;

  int nchk;
  int nerr;

  bist_response_analyzer_if #(.size(8), .aw(4), .cw(8)) b0 ();
  bist_response_analyzer_if #(.size(8), .aw(4), .cw(2)) b1 ();

  assign b0.sel      = sel;
  assign b0.ram_dout = ram_dout;
  assign b0.start    = start;
  assign b0.rd_en    = rd_en;
  assign b0.rd_addr  = rd_addr;
  assign b0.exp_data = exp_data;
  assign b0.test_end = test_end;
  assign b1.sel      = sel;
  assign b1.ram_dout = ram_dout;
  assign b1.start    = start;
  assign b1.rd_en    = rd_en;
  assign b1.rd_addr  = rd_addr;
  assign b1.exp_data = exp_data;
  assign b1.test_end = test_end;

  bist_response_analyzer #(.size(8), .aw(4), .cw(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
  bist_response_analyzer #(.size(8), .aw(4), .cw(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reads addr from..to-1 (A5 expected); ram_dout carries the previous read's data.
  // test_end coincides with the read of addr 15.
  task automatic reads(input int from, input int to, input logic [15:0] faults);
    for (int i = from; i < to; i++) begin
      rd_en    = 1'b1;
      rd_addr  = i[3:0];
      exp_data = 8'hA5;
      test_end = (i == 15);
      if (i > 0) ram_dout = faults[i-1] ? 8'hA4 : 8'hA5;
      else       ram_dout = 8'h00;
      tick();
    end
  endtask

  // DRAIN cycle: deliver data for read 15, no new strobes
  task automatic drain(input logic [15:0] faults);
    rd_en    = 1'b0;
    test_end = 1'b0;
    ram_dout = faults[15] ? 8'hA4 : 8'hA5;
    tick();
    ram_dout = 8'h00;
  endtask

  task automatic do_start();
    sel   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst = 1'b1; sel = 1'b0; ram_dout = 8'h00; start = 1'b0;
    rd_en = 1'b0; rd_addr = 4'h0; exp_data = 8'h00; test_end = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_busy", b0.busy, 1'b0);
    chk("rst_done", b0.done, 1'b0);
    chk("rst_pass", b0.pass, 1'b0);
    chk("rst_fail", b0.fail, 1'b0);
    chk("rst_cnt",  b0.fail_count, 8'd0);
    chk("rst_ffa",  b0.first_fail_addr, 4'd0);
    chk("rst_ffd",  b0.first_fail_data, 8'd0);

    // functional mode: pass-through and start ignored
    ram_dout = 8'h3C; #1;
    chk("sys_3c", b0.sys_dout, 8'h3C);
    ram_dout = 8'hC3; #1;
    chk("sys_c3", b0.sys_dout, 8'hC3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sel0_start_ignored", b0.busy, 1'b0);
    sel = 1'b1; ram_dout = 8'h3C; #1;
    chk("sys_bist_zero", b0.sys_dout, 8'h00);

    // clean run
    do_start();
    chk("clean_busy_run", b0.busy, 1'b1);
    reads(0, 16, 16'h0000);
    chk("clean_drain_busy", b0.busy, 1'b1);
    chk("clean_drain_done", b0.done, 1'b0);
    drain(16'h0000);
    chk("clean_done", b0.done, 1'b1);
    chk("clean_pass", b0.pass, 1'b1);
    chk("clean_fail", b0.fail, 1'b0);
    chk("clean_cnt", b0.fail_count, 8'd0);
    chk("clean_busy_end", b0.busy, 1'b0);

    // single fault at addr 6, restarted from DONE
    do_start();
    chk("sf_restart_done", b0.done, 1'b0);
    reads(0, 7, 16'h0040);
    chk("sf_fail_before", b0.fail, 1'b0);
    reads(7, 8, 16'h0040);
    chk("sf_fail_after", b0.fail, 1'b1);
    chk("sf_cnt_mid", b0.fail_count, 8'd1);
    reads(8, 16, 16'h0040);
    drain(16'h0040);
    chk("sf_done", b0.done, 1'b1);
    chk("sf_pass", b0.pass, 1'b0);
    chk("sf_cnt", b0.fail_count, 8'd1);
    chk("sf_ffa", b0.first_fail_addr, 4'd6);
    chk("sf_ffd", b0.first_fail_data, 8'hA4);

    // faults at 3, 9, 12
    do_start();
    reads(0, 16, 16'h1208);
    drain(16'h1208);
    chk("mf_cnt", b0.fail_count, 8'd3);
    chk("mf_ffa", b0.first_fail_addr, 4'd3);
    chk("mf_cnt_cw2", b1.fail_count, 2'd3);

    // faults at 3, 5, 9, 12, 15 (last coincident with test_end)
    do_start();
    reads(0, 16, 16'h9228);
    chk("sat_cnt_pre", b0.fail_count, 8'd4);
    drain(16'h9228);
    chk("sat_cnt", b0.fail_count, 8'd5);
    chk("sat_cnt_cw2", b1.fail_count, 2'd3);
    chk("sat_ffa", b0.first_fail_addr, 4'd3);
    chk("sat_ffa_cw2", b1.first_fail_addr, 4'd3);
    chk("edge_done", b0.done, 1'b1);
    chk("edge_fail", b0.fail, 1'b1);
    chk("edge_pass", b0.pass, 1'b0);

    // restart from DONE clears results
    do_start();
    chk("rs_fail", b0.fail, 1'b0);
    chk("rs_cnt", b0.fail_count, 8'd0);
    chk("rs_ffa", b0.first_fail_addr, 4'd0);
    chk("rs_ffd", b0.first_fail_data, 8'd0);
    chk("rs_done", b0.done, 1'b0);
    chk("rs_busy", b0.busy, 1'b1);

    // abort by dropping sel; pending compare on read 5 is discarded
    reads(0, 6, 16'h0034);
    chk("ab_cnt_pre", b0.fail_count, 8'd2);
    sel = 1'b0; rd_en = 1'b0; test_end = 1'b0; ram_dout = 8'hA4; #1;
    chk("ab_sys", b0.sys_dout, 8'hA4);
    tick();
    chk("ab_busy", b0.busy, 1'b0);
    chk("ab_done", b0.done, 1'b0);
    chk("ab_fail", b0.fail, 1'b1);
    chk("ab_cnt", b0.fail_count, 8'd2);
    chk("ab_ffa", b0.first_fail_addr, 4'd2);
    chk("ab_ffd", b0.first_fail_data, 8'hA4);

    // reset mid-run after two fails
    do_start();
    reads(0, 5, 16'h000A);
    chk("mr_cnt_pre", b0.fail_count, 8'd2);
    rst = 1'b1; rd_en = 1'b0; ram_dout = 8'hA4;
    tick();
    rst = 1'b0;
    chk("mr_busy", b0.busy, 1'b0);
    chk("mr_done", b0.done, 1'b0);
    chk("mr_pass", b0.pass, 1'b0);
    chk("mr_fail", b0.fail, 1'b0);
    chk("mr_cnt", b0.fail_count, 8'd0);
    chk("mr_cnt_cw2", b1.fail_count, 2'd0);
    chk("mr_ffa", b0.first_fail_addr, 4'd0);
    chk("mr_ffd", b0.first_fail_data, 8'd0);
    tick();
    chk("mr_idle_busy", b0.busy, 1'b0);
    chk("mr_idle_fail", b0.fail, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bist_response_analyzer.md
# bist_response_analyzer

Read-side counterpart of the RAM input multiplexer in the BIST datapath. The multiplexer chooses whether the system or the BIST engine drives the RAM; this block sits on the RAM read-data output and routes that data the other way. In functional mode it passes read data to the system port. In test mode it compares each RAM read against the BIST engine's expected pattern and records a sticky fail flag, a saturating fail count, and the address and data of the first miscompare.

## Interface
Parameters:
- size, 8, RAM data width
- aw, 4, RAM address width
- cw, 8, fail counter width

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- sel  input  1  mode select, same meaning as the input mux: 0 = system owns the RAM, 1 = BIST owns it
- ram_dout  input  size  RAM read data; valid one cycle after the read strobe
- sys_dout  output  size  read data to the system; equals ram_dout when sel=0, all zeros when sel=1 (combinational)
- start  input  1  one-cycle pulse from the BIST engine; clears results and begins a run
- rd_en  input  1  BIST read strobe, issued in the same cycle the address is applied to the RAM
- rd_addr  input  aw  address of the current BIST read
- exp_data  input  size  expected data for the current BIST read
- test_end  input  1  one-cycle pulse coinciding with or following the last rd_en
- busy  output  1  high in RUN or DRAIN
- done  output  1  high in DONE
- pass  output  1  equals done & ~fail
- fail  output  1  sticky miscompare flag
- fail_count  output  cw  number of miscompares, saturating at 2^cw-1
- first_fail_addr  output  aw  address of the first miscompare
- first_fail_data  output  size  RAM data read at the first miscompare

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE -> RUN when start=1 and sel=1. On this transition, fail, fail_count, first_fail_addr, first_fail_data and the pending-compare flag all clear. start with sel=0 is ignored.
- RUN: when rd_en=1, register rd_addr and exp_data into stage 1 and set the pending flag. The next cycle compares ram_dout with the stage-1 expected data.
- A miscompare sets fail, increments fail_count (saturating), and loads first_fail_addr and first_fail_data if fail was previously 0.
- Back-to-back rd_en every cycle is supported; stage 1 reloads each cycle.
- RUN -> DRAIN on test_end. If rd_en and test_end arrive in the same cycle, that read is captured normally.
- DRAIN: completes any pending compare, then moves to DONE after exactly one cycle. rd_en is ignored in DRAIN and DONE.
- DONE: holds all results. start with sel=1 -> RUN with results cleared.
- sel=0 in RUN, DRAIN or DONE aborts to IDLE. Results are retained, the pending compare is discarded and done drops.
- start received in RUN or DRAIN restarts the run: results clear and the state stays or returns to RUN.
- Reset value of every registered output is 0: busy, done, pass, fail, fail_count, first_fail_addr, first_fail_data.

## Timing
- Read strobe in cycle t -> compare in cycle t+1 -> fail and fail_count visible after the rising edge ending cycle t+1.
- test_end in cycle t -> DRAIN in t+1 -> done=1 from t+2, with all results final.
- sys_dout has zero latency and no state.
- rst has priority over every other input and takes effect at the next edge, including mid-run and mid-compare.

## Test plan
- Clean run: sel=1, start, 16 reads at addr 0..15 with ram_dout equal to exp_data=8'hA5, then test_end -> done=1 two cycles after test_end, pass=1, fail_count=0.
- Single fault: as above, but ram_dout=8'hA4 at addr 6 -> fail=1 one cycle after the compare, fail_count=1, first_fail_addr=6, first_fail_data=8'hA4, pass=0.
- Multiple faults: miscompares at addr 3, 9 and 12 -> fail_count=3, first_fail_addr=3 (not overwritten). With cw=2 and 5 faults -> fail_count saturates at 3.
- Boundary timing: rd_en coincident with test_end on a miscompare -> the fail is counted and done is asserted with fail=1. Restart from DONE -> all results return to 0.
- Mode handling: sel=0 -> sys_dout tracks ram_dout cycle-for-cycle (e.g. 8'h3C) and start is ignored. With sel=1, sys_dout=0. Dropping sel mid-run -> IDLE, results retained.
- Reset mid-run after 2 fails: rst for one cycle -> all outputs 0 and state IDLE on the following cycle.
